// File: rtl/top_spi_main_memory.sv
// SPI mode-0 slave bridging a two-byte command/data protocol onto a small byte register file.
// Define SPI_ID_REG_EN to expose a read-only ID register (8'hC5) at address 7'h7F.
module top_spi_main_memory #(
  parameter int unsigned MEM_DEPTH            = 16,
  parameter logic [6:0]  CH_MUX_SELECTOR_ADDR = 7'h00,
  parameter logic [6:0]  CH_MUX_ENABLE_ADDR   = 7'h01
) (
  input  logic       i_clk_10,
  input  logic       i_rst,
  input  logic       i_MOSI,
  input  logic       i_SCLK,
  input  logic       i_SSEL,
  output logic       o_MISO,
  output logic [3:0] o_enable,
  output logic [3:0] o_selector
);

  localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [7:0]  DEPTH_W = 8'(MEM_DEPTH);

  typedef enum logic {StCommand, StData} phase_e;

  phase_e      phase_q, phase_d;
  logic [2:0]  sclk_sync_q;
  logic [1:0]  ssel_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  mem_q [MEM_DEPTH];
  logic [3:0]  sel_q, ena_q;

  logic        sclk_rise, sclk_fall, ssel_active, mosi_s;
  logic [7:0]  rx_byte, rd_data;
  logic        wr_en, wr_ok;

  // Index 1 is the synchronized level, index 2 its previous value for edge detection.
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ssel_active = ~ssel_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];
  assign rx_byte     = {rx_q, mosi_s};

  always_comb begin
    rd_data = 8'h00;
    if ({1'b0, rx_byte[6:0]} < DEPTH_W) begin
      rd_data = mem_q[rx_byte[AW-1:0]];
    end
`ifdef SPI_ID_REG_EN
    if (rx_byte[6:0] == 7'h7F) begin
      rd_data = 8'hC5;
    end
`endif
  end

  always_comb begin
    wr_ok = ({1'b0, cmd_q[6:0]} < DEPTH_W);
`ifdef SPI_ID_REG_EN
    if (cmd_q[6:0] == 7'h7F) begin
      wr_ok = 1'b0;
    end
`else
    wr_ok = wr_ok;
`endif
  end

  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    wr_en     = 1'b0;
    if (!ssel_active) begin
      // Deselect drops any partial byte but keeps the transaction phase.
      bit_cnt_d = 3'd0;
      rx_d      = 7'd0;
    end else if (sclk_rise) begin
      rx_d      = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        unique case (phase_q)
          StCommand: begin
            cmd_d   = rx_byte;
            phase_d = StData;
            if (!rx_byte[7]) begin
              tx_d = rd_data;
            end
          end
          StData: begin
            wr_en   = cmd_q[7];
            phase_d = StCommand;
          end
          default: phase_d = StCommand;
        endcase
      end
    end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
      tx_d = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync_q <= 3'b111;
      ssel_sync_q <= 2'b11;
      mosi_sync_q <= 2'b00;
      phase_q     <= StCommand;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'h00;
      cmd_q       <= 8'h00;
      sel_q       <= 4'h0;
      ena_q       <= 4'h0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], i_SCLK};
      ssel_sync_q <= {ssel_sync_q[0], i_SSEL};
      mosi_sync_q <= {mosi_sync_q[0], i_MOSI};
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_q       <= cmd_d;
      sel_q       <= mem_q[CH_MUX_SELECTOR_ADDR[AW-1:0]][3:0];
      ena_q       <= mem_q[CH_MUX_ENABLE_ADDR[AW-1:0]][3:0];
      if (wr_en && wr_ok) begin
        mem_q[cmd_q[AW-1:0]] <= rx_byte;
      end
    end
  end

  assign o_MISO     = ssel_active & (phase_q == StData) & ~cmd_q[7] & tx_q[7];
  assign o_selector = sel_q;
  assign o_enable   = ena_q;

endmodule

// File: tb/tb_top_spi_main_memory.sv
// Scoreboard bench: stimulus queues expected values, a monitor process compares DUT outputs.
module tb_top_spi_main_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi, sclk, ssel;
  logic       miso;
  logic [3:0] enable, selector;

  top_spi_main_memory dut (
    .i_clk_10  (clk),
    .i_rst     (rst),
    .i_MOSI    (mosi),
    .i_SCLK    (sclk),
    .i_SSEL    (ssel),
    .o_MISO    (miso),
    .o_enable  (enable),
    .o_selector(selector)
  );

  always #50 clk = ~clk;

  typedef enum int {KMisoByte, KSel, KEna, KMisoPin} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  event       sample_ev;
  logic [7:0] miso_byte;
  int         n_vec = 0;
  int         n_err = 0;

  // Monitor: drains every pending expectation against the DUT each time outputs are presented.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          KMisoByte: act = miso_byte;
          KSel:      act = {4'h0, selector};
          KEna:      act = {4'h0, enable};
          default:   act = {7'h00, miso};
        endcase
        n_vec++;
        if (act !== e.val) begin
          n_err++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(input kind_e k, input logic [7:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic present();
    -> sample_ev;
    #10;
  endtask

  // Shifts n bits (MSB first) of b inside one SSEL frame; SCLK idles high.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx   = 8'h00;
    ssel = 1'b0;
    #600;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      mosi = b[i];
      #400;
      rx[i] = miso;
      sclk  = 1'b1;
      #400;
    end
    #400;
    ssel = 1'b1;
    #600;
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] unused_rx;
    spi_bits(cmd, 8, unused_rx);
    spi_bits(data, 8, miso_byte);
    repeat (3) @(posedge clk);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] v);
    xfer({1'b1, a}, v);
  endtask

  task automatic rd_chk(input logic [6:0] a, input logic [7:0] v, input string nm);
    xfer({1'b0, a}, 8'h63);
    expect_val(KMisoByte, v, nm);
    present();
  endtask

  task automatic regs_chk(input logic [3:0] s, input logic [3:0] en, input string nm);
    expect_val(KSel, {4'h0, s}, {nm, "_sel"});
    expect_val(KEna, {4'h0, en}, {nm, "_ena"});
    present();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    rst  = 1'b1;
    ssel = 1'b1;
    sclk = 1'b1;
    mosi = 1'b0;
    #10us;
    rst = 1'b0;
    #200;
    regs_chk(4'h0, 4'h0, "reset");
    expect_val(KMisoPin, 8'h00, "reset_miso");
    present();
    rd_chk(7'h00, 8'h00, "rd_reset_0");

    wr(7'h00, 8'h81);
    regs_chk(4'h1, 4'h0, "wr_sel");
    wr(7'h01, 8'h42);
    regs_chk(4'h1, 4'h2, "wr_ena");
    rd_chk(7'h00, 8'h81, "rd_sel");
    rd_chk(7'h01, 8'h42, "rd_ena");
    regs_chk(4'h1, 4'h2, "after_dummy");

    // Abort a command byte after four bits; the next full transaction must still decode.
    spi_bits(8'hFF, 4, rx);
    wr(7'h01, 8'h0F);
    regs_chk(4'h1, 4'hF, "abort_then_wr");
    rd_chk(7'h01, 8'h0F, "rd_after_abort");

    wr(7'h20, 8'h55);
    regs_chk(4'h1, 4'hF, "oor_wr");
    rd_chk(7'h20, 8'h00, "rd_oor_20");
    wr(7'h10, 8'h77);
    rd_chk(7'h10, 8'h00, "rd_oor_depth");
    wr(7'h0F, 8'hA5);
    rd_chk(7'h0F, 8'hA5, "rd_top_addr");
    wr(7'h7F, 8'h12);
`ifdef SPI_ID_REG_EN
    rd_chk(7'h7F, 8'hC5, "rd_id");
`else
    rd_chk(7'h7F, 8'h00, "rd_7f");
`endif
    regs_chk(4'h1, 4'hF, "after_oor");

    // Reset in the middle of a write data byte.
    spi_bits(8'h80, 8, rx);
    ssel = 1'b0;
    #600;
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0;
      mosi = 1'b1;
      #400;
      sclk = 1'b1;
      #400;
    end
    rst = 1'b1;
    #20;
    regs_chk(4'h0, 4'h0, "midrst");
    expect_val(KMisoPin, 8'h00, "midrst_miso");
    present();
    ssel = 1'b1;
    #500;
    rst = 1'b0;
    #300;
    wr(7'h01, 8'h03);
    regs_chk(4'h0, 4'h3, "post_rst_wr");
    rd_chk(7'h00, 8'h00, "post_rst_rd");

    #1us;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
